door_input_cond: RTL and testbench
==================================

Name: door_input_cond

Overview:
- Input conditioning stage placed directly upstream of the door control FSM.
- Takes raw asynchronous push-button and limit-switch levels from the board and runs each one through a synchroniser and a debouncer.
- Outputs clean single-cycle key press pulses and stable sensor levels that the door FSM consumes.
- Flags a limit-switch plausibility fault, i.e. both end positions reported at once.

Parameters:
- DEB_CYCLES, 20000, consecutive stable cycles required before a debounced level changes (10 ms at 2 MHz); legal range 2..65535.
- STUCK_CYCLES, 20000000, cycles a key must be held before key_stuck asserts (10 s at 2 MHz); only used with DOOR_IN_STUCK_DET_EN.

Ports:
- clk2m, input, 1, 2 MHz system clock; all state on its rising edge.
- rst, input, 1, reset: synchronous, active-high.
- key_up_raw, input, 1, raw "open" button, active-high, asynchronous, bouncing.
- key_down_raw, input, 1, raw "close" button, active-high, asynchronous, bouncing.
- sense_up_raw, input, 1, raw upper limit switch, active-high, asynchronous.
- sense_down_raw, input, 1, raw lower limit switch, active-high, asynchronous.
- key_up, output, 1, one-cycle pulse per accepted "open" press.
- key_down, output, 1, one-cycle pulse per accepted "close" press.
- sense_up, output, 1, debounced upper limit level (gated by fault).
- sense_down, output, 1, debounced lower limit level (gated by fault).
- sense_fault, output, 1, both debounced limit switches high.
- key_stuck, output, 1, a key held for at least STUCK_CYCLES.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All synchroniser flops, debounced levels, counters and registered outputs go to 0.
  - Reset mid-bounce discards any partial count.
- Synchroniser: 2-flop chain per raw input; sync = second flop.
- Debouncer, one per channel, holding a stable level db and a counter cnt (16 bit):
  - sync == db: cnt <= 0.
  - sync != db and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - sync != db and cnt == DEB_CYCLES-1: db <= sync, cnt <= 0.
  - db therefore flips on the DEB_CYCLES-th consecutive edge at which sync differs from db.
  - A single glitch back to the old value restarts the count from 0.
  - Latency from a clean raw step to a db change: DEB_CYCLES+2 rising edges.
- Key pulse generation:
  - Registered rising-edge detect on db_key: pulse = db & ~db_prev, registered.
  - key_up/key_down is therefore high exactly one cycle, one edge after db rises.
  - Releasing a key produces no pulse.
- Key mutual exclusion:
  - If the other key's db is 1 in the same cycle as a rising edge, the pulse is suppressed.
  - This covers both keys rising together and pressing one key while the other is held.
  - key_up and key_down are never high in the same cycle.
- A key held through reset release counts as a new press: a pulse appears DEB_CYCLES+3 edges after rst deasserts.
- Sensor outputs:
  - sense_up = db_sense_up & ~fault; sense_down = db_sense_down & ~fault (combinational from registers).
  - sense_fault = db_sense_up & db_sense_down.
  - While the fault is present both sense outputs read 0, so the FSM sees neither end position.
  - The fault clears as soon as either debounced level drops.
- All outputs depend only on registered state; there is no combinational path from the raw inputs.

Optional Feature:
- Macro DOOR_IN_STUCK_DET_EN.
- Defined:
  - A 25-bit per-key hold counter increments while that key's db=1 and saturates at STUCK_CYCLES.
  - key_stuck is a registered output that goes to 1 on the edge the counter of either key reaches STUCK_CYCLES.
  - key_stuck stays 1 until that key's db returns to 0; counter and flag then clear on the next edge.
  - While a key is stuck, no key_up/key_down pulses are generated for either key.
- Not defined: the counters do not exist, key_stuck is tied to 0, and pulse generation is unaffected.

Test Plan (DEB_CYCLES=4, STUCK_CYCLES=50 in simulation):
- Reset: hold rst=1 for 3 cycles with all raw inputs toggling → all outputs 0 during reset and on the first edge after release.
- Clean press: key_up_raw 0→1 held for 20 cycles → key_up high for exactly one cycle, 7 edges after the step; key_down stays 0; release produces no pulse.
- Bounce: key_down_raw pattern 1,0,1,1,0,1,1,1,1,1 → exactly one key_down pulse, 7 edges after the final 0→1; shorter runs produce no pulse.
- Conflict: key_up_raw and key_down_raw rise on the same edge, then key_up_raw released while key_down_raw held → no pulses; re-pressing key_up while key_down is held → still no pulse.
- Sensor fault: sense_down_raw=1 stable, then sense_up_raw=1 → sense_down=1 until sense_fault=1 (6 edges after the sense_up_raw step), then sense_up=sense_down=0; dropping sense_up_raw restores sense_down=1 after 6 edges.
- Stuck key (macro defined): hold key_up_raw for 100 cycles → one pulse, then key_stuck=1 when the hold counter reaches 50; pressing key_down_raw meanwhile gives no pulse; releasing key_up_raw clears key_stuck. With the macro undefined, key_stuck stays 0.

Source files
------------

// File: rtl/door_input_cond.sv
// Input conditioning for the door controller.
// Each raw push-button and limit-switch level passes through a 2-flop synchroniser and a
// debouncer. The block then produces single-cycle key press pulses, sensor levels masked by
// fault, and a plausibility fault raised when both limit switches read high.
//
// Optional feature: define DOOR_IN_STUCK_DET_EN to enable stuck-key detection. Without it,
// key_stuck is tied low.
//
// Ports:
//   clk2m          2 MHz clock; all state changes on its rising edge
//   rst            synchronous, active-high reset
//   key_up_raw     raw "open" button (asynchronous, bouncing)
//   key_down_raw   raw "close" button (asynchronous, bouncing)
//   sense_up_raw   raw upper limit switch (asynchronous)
//   sense_down_raw raw lower limit switch (asynchronous)
//   key_up         one-cycle pulse for each accepted "open" press
//   key_down       one-cycle pulse for each accepted "close" press
//   sense_up       debounced upper limit, forced low while sense_fault is high
//   sense_down     debounced lower limit, forced low while sense_fault is high
//   sense_fault    both debounced limit switches are high
//   key_stuck      a key has been held for STUCK_CYCLES (stuck detection only)
module door_input_cond #(
  parameter int unsigned DEB_CYCLES   = 20000,
  parameter int unsigned STUCK_CYCLES = 20000000
) (
  input  logic clk2m,
  input  logic rst,
  input  logic key_up_raw,
  input  logic key_down_raw,
  input  logic sense_up_raw,
  input  logic sense_down_raw,
  output logic key_up,
  output logic key_down,
  output logic sense_up,
  output logic sense_down,
  output logic sense_fault,
  output logic key_stuck
);

  // Channel order: 0 key_up, 1 key_down, 2 sense_up, 3 sense_down
  localparam logic [15:0] DebLast = 16'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535 || STUCK_CYCLES > 33554431) begin : g_bad_param
    $error("door_input_cond: DEB_CYCLES or STUCK_CYCLES out of range");
  end

  logic [3:0] raw;
  assign raw = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};

  // Synchronisers
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk2m) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: db follows sync only after DEB_CYCLES consecutive disagreeing edges
  logic [3:0]       db_q, db_d;
  logic [3:0][15:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] >= DebLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk2m) begin
    if (rst) begin
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Stuck-key detection
  logic stuck;

`ifdef DOOR_IN_STUCK_DET_EN
  localparam logic [24:0] StuckMax = 25'(STUCK_CYCLES);

  logic [1:0][24:0] hold_q, hold_d;
  logic             stuck_q, stuck_d;

  always_comb begin
    hold_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (db_q[i]) begin
        hold_d[i] = (hold_q[i] >= StuckMax) ? StuckMax : hold_q[i] + 25'd1;
      end
    end
    // Flag rises on the same edge a counter saturates; drops when the held key's db returns low
    stuck_d = (hold_d[0] == StuckMax) | (hold_d[1] == StuckMax);
  end

  always_ff @(posedge clk2m) begin
    if (rst) begin
      hold_q  <= '0;
      stuck_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  // Key pulse generation: registered rising edge of db, suppressed while the other key is
  // down or while a key is stuck
  logic [1:0] db_prev_q;
  logic       key_up_q, key_down_q;
  logic       key_up_d, key_down_d;

  always_comb begin
    key_up_d   = db_q[0] & ~db_prev_q[0] & ~db_q[1] & ~stuck;
    key_down_d = db_q[1] & ~db_prev_q[1] & ~db_q[0] & ~stuck;
  end

  always_ff @(posedge clk2m) begin
    if (rst) begin
      db_prev_q  <= '0;
      key_up_q   <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      db_prev_q  <= db_q[1:0];
      key_up_q   <= key_up_d;
      key_down_q <= key_down_d;
    end
  end

  // Outputs depend on registered state only
  assign key_up      = key_up_q;
  assign key_down    = key_down_q;
  assign key_stuck   = stuck;
  assign sense_fault = db_q[2] & db_q[3];
  assign sense_up    = db_q[2] & ~sense_fault;
  assign sense_down  = db_q[3] & ~sense_fault;

endmodule

// File: tb/tb_door_input_cond.sv
// Testbench for door_input_cond. A reference model runs on each rising edge and pushes the
// expected output vector into a queue. A monitor on the falling edge pops each entry and
// compares it with the DUT outputs. Directed phases also check the latencies the design
// guarantees.
module tb_door_input_cond;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Stuck = 50;
`ifdef DOOR_IN_STUCK_DET_EN
  localparam bit StuckEn = 1'b1;
`else
  localparam bit StuckEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_up_raw = 1'b0, key_down_raw = 1'b0, sense_up_raw = 1'b0, sense_down_raw = 1'b0;
  logic key_up, key_down, sense_up, sense_down, sense_fault, key_stuck;

  door_input_cond #(
    .DEB_CYCLES  (Deb),
    .STUCK_CYCLES(Stuck)
  ) dut (
    .clk2m         (clk),
    .rst           (rst),
    .key_up_raw    (key_up_raw),
    .key_down_raw  (key_down_raw),
    .sense_up_raw  (sense_up_raw),
    .sense_down_raw(sense_down_raw),
    .key_up        (key_up),
    .key_down      (key_down),
    .sense_up      (sense_up),
    .sense_down    (sense_down),
    .sense_fault   (sense_fault),
    .key_stuck     (key_stuck)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Order of the expected vector: key_up, key_down, sense_up, sense_down, sense_fault, key_stuck
  logic [5:0] exp_q[$];

  bit       started = 0;
  bit [3:0] m_s1, m_s2, m_db;
  bit [1:0] m_dbp;
  bit       m_pu, m_pd, m_stuck;
  int       held[2];
  bit       win[4][Deb];   // last Deb synchronised samples per channel
  int       fill[4];

  always @(posedge clk) begin
    bit [3:0] rawv;
    bit       pu, pd, flt, all_diff;
    rawv = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};
    if (rst) begin
      started = 1;
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
      m_pu = 0; m_pd = 0; m_stuck = 0;
      for (int i = 0; i < 2; i++) held[i] = 0;
      for (int c = 0; c < 4; c++) fill[c] = 0;
    end else if (started) begin
      // A press is accepted on the cycle after db rises, unless the other key or stuck blocks it
      pu = m_db[0] && !m_dbp[0] && !m_db[1] && !m_stuck;
      pd = m_db[1] && !m_dbp[1] && !m_db[0] && !m_stuck;
      for (int i = 0; i < 2; i++) begin
        if (m_db[i]) held[i] = (held[i] + 1 > int'(Stuck)) ? int'(Stuck) : held[i] + 1;
        else         held[i] = 0;
      end
      m_stuck = StuckEn && (held[0] == int'(Stuck) || held[1] == int'(Stuck));
      m_dbp = m_db[1:0];
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < int'(Deb) - 1; k++) win[c][k] = win[c][k+1];
        win[c][Deb-1] = m_s2[c];
        if (fill[c] < int'(Deb)) fill[c]++;
        all_diff = 1;
        for (int k = 0; k < int'(Deb); k++) if (win[c][k] == m_db[c]) all_diff = 0;
        if (fill[c] == int'(Deb) && all_diff) m_db[c] = ~m_db[c];
      end
      m_s2 = m_s1;
      m_s1 = rawv;
      m_pu = pu;
      m_pd = pd;
    end
    if (started) begin
      flt = m_db[2] & m_db[3];
      exp_q.push_back({m_pu, m_pd, m_db[2] & ~flt, m_db[3] & ~flt, flt, m_stuck});
    end
  end

  // ---------------- monitor ----------------
  int up_cnt = 0, dn_cnt = 0;
  int last_up_cyc = -1, last_dn_cyc = -1, fault_rise_cyc = -1, sd_rise_cyc = -1;
  bit stuck_seen = 0;
  bit prev_fault = 0, prev_sd = 0;

  always @(negedge clk) begin
    logic [5:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {key_up, key_down, sense_up, sense_down, sense_fault, key_stuck};
      check("outputs", int'(a), int'(e));
      check("keys_exclusive", int'(key_up & key_down), 0);
      if (key_up === 1'b1) begin up_cnt++; last_up_cyc = cyc; end
      if (key_down === 1'b1) begin dn_cnt++; last_dn_cyc = cyc; end
      if (sense_fault === 1'b1 && !prev_fault) fault_rise_cyc = cyc;
      if (sense_down === 1'b1 && !prev_sd) sd_rise_cyc = cyc;
      if (key_stuck === 1'b1) stuck_seen = 1;
      prev_fault = (sense_fault === 1'b1);
      prev_sd    = (sense_down === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, u0, d0;
    bit bounce[10];
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    // Reset with inputs toggling
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_up_raw = ~key_up_raw; key_down_raw = $urandom_range(0, 1);
      sense_up_raw = ~sense_up_raw; sense_down_raw = $urandom_range(0, 1);
      @(negedge clk);
    end
    check("reset_outputs", int'({key_up, key_down, sense_up, sense_down, sense_fault, key_stuck}),
          0);
    rst = 1'b0;
    key_up_raw = 0; key_down_raw = 0; sense_up_raw = 0; sense_down_raw = 0;
    wait_cyc(12);

    // Clean press of "open"
    u0 = up_cnt; d0 = dn_cnt;
    key_up_raw = 1'b1; c0 = cyc;
    wait_cyc(20);
    key_up_raw = 1'b0;
    wait_cyc(12);
    check("clean_up_pulses", up_cnt - u0, 1);
    check("clean_down_pulses", dn_cnt - d0, 0);
    check("clean_latency", last_up_cyc - c0, 7);

    // Bouncing "close"
    d0 = dn_cnt; c0 = 0;
    for (int i = 0; i < 10; i++) begin
      key_down_raw = bounce[i];
      if (i == 5) c0 = cyc;
      @(negedge clk);
    end
    wait_cyc(15);
    check("bounce_pulses", dn_cnt - d0, 1);
    check("bounce_latency", last_dn_cyc - c0, 7);
    key_down_raw = 1'b0;
    wait_cyc(12);

    // Conflicting keys
    u0 = up_cnt; d0 = dn_cnt;
    key_up_raw = 1'b1; key_down_raw = 1'b1;
    wait_cyc(15);
    key_up_raw = 1'b0;
    wait_cyc(10);
    key_up_raw = 1'b1;
    wait_cyc(15);
    key_up_raw = 1'b0; key_down_raw = 1'b0;
    wait_cyc(12);
    check("conflict_up_pulses", up_cnt - u0, 0);
    check("conflict_down_pulses", dn_cnt - d0, 0);

    // Limit switch plausibility fault
    sense_down_raw = 1'b1;
    wait_cyc(10);
    check("sense_down_level", int'(sense_down), 1);
    sense_up_raw = 1'b1; c0 = cyc;
    wait_cyc(12);
    check("fault_latency", fault_rise_cyc - c0, 6);
    check("fault_masks", int'({sense_up, sense_down, sense_fault}), 1);
    sense_up_raw = 1'b0; c0 = cyc;
    wait_cyc(12);
    check("fault_clear_latency", sd_rise_cyc - c0, 6);
    check("fault_cleared", int'({sense_up, sense_down, sense_fault}), 2);
    sense_down_raw = 1'b0;
    wait_cyc(10);

    // Long hold of "open"
    u0 = up_cnt; d0 = dn_cnt; stuck_seen = 0;
    key_up_raw = 1'b1;
    wait_cyc(70);
    key_down_raw = 1'b1;
    wait_cyc(15);
    key_down_raw = 1'b0;
    wait_cyc(15);
    key_up_raw = 1'b0;
    wait_cyc(12);
    check("hold_up_pulses", up_cnt - u0, 1);
    check("hold_down_pulses", dn_cnt - d0, 0);
    check("stuck_seen", int'(stuck_seen), int'(StuckEn));
    check("stuck_cleared", int'(key_stuck), 0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) key_up_raw = ~key_up_raw;
      if ($urandom_range(0, 7) == 0) key_down_raw = ~key_down_raw;
      if ($urandom_range(0, 9) == 0) sense_up_raw = ~sense_up_raw;
      if ($urandom_range(0, 9) == 0) sense_down_raw = ~sense_down_raw;
      if (i % 700 == 350) key_up_raw = 1'b1;  // long holds give stuck detection a chance
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    wait_cyc(3);
    check("queue_drained", (exp_q.size() <= 1) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case the stimulus above ever stalls
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
